// File: rtl/lsu_mem_if.sv
// Load/store unit, initiator side of a word-only data memory.
// Accepts RV32I loads/stores, extracts and extends sub-word loads, performs
// SB/SH as a read-modify-write, and reports misaligned or illegal requests.
// Faulting requests complete straight from idle: their response is registered
// on acceptance, so they never leave the idle state and never touch memory.
module lsu_mem_if #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {StIdle, StLoad, StRmwRd, StWrite} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic              accept;

  // Illegal funct3 for the direction, or address not aligned to the access size.
  function automatic logic is_fault(logic we, logic [2:0] f3, logic [1:0] a);
    logic bad_op;
    logic misal;
    if (we) bad_op = f3[2] | (f3[1:0] == 2'b11);
    else    bad_op = (f3[1:0] == 2'b11) | (f3 == 3'b110);
    misal = ((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00));
    return bad_op | misal;
  endfunction

  // Select the addressed lane and sign/zero extend according to funct3.
  function automatic logic [31:0] load_ext(logic [2:0] f3, logic [1:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    unique case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Replace the target byte/half of the read word with the store data.
  function automatic logic [31:0] store_merge(logic [2:0] f3, logic [1:0] a,
                                              logic [31:0] old, logic [31:0] wd);
    logic [31:0] mask;
    logic [31:0] data;
    if (f3[0]) begin
      mask = 32'h0000_FFFF << {a[1], 4'b0000};
      data = {2{wd[15:0]}};
    end else begin
      mask = 32'h0000_00FF << {a, 3'b000};
      data = {4{wd[7:0]}};
    end
    return (old & ~mask) | (data & mask);
  endfunction

  assign req_ready = (state_q == StIdle) & ~rst;
  assign accept    = req_valid & req_ready;
  assign stall     = accept | (state_q != StIdle);

  // Next-state, request latching and response generation.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_fault_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (is_fault(req_we, req_funct3, req_addr[1:0])) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else if (!req_we) begin
            state_d = StLoad;
          end else if (req_funct3[1:0] == 2'b10) begin
            state_d = StWrite;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        rsp_rdata_d = load_ext(f3_q, addr_q[1:0], mem_read_data);
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      StRmwRd: begin
        // The merged word reuses the store-data register for the write cycle.
        wdata_d = store_merge(f3_q, addr_q[1:0], mem_read_data, wdata_q);
        state_d = StWrite;
      end
      StWrite: begin
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Memory-side outputs are quiet whenever no access is in flight.
  always_comb begin
    mem_address    = '0;
    mem_write_data = 32'h0;
    mem_write      = 1'b0;
    if (state_q != StIdle) begin
      mem_address = {addr_q[ADDR_W-1:2], 2'b00};
    end
    if (state_q == StWrite) begin
      mem_write_data = wdata_q;
      // A reset landing on the write cycle must not commit the write.
      mem_write      = ~rst;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule
